// File: rtl/conv2x2_host_driver.sv
// Host-side initiator for the 2x2 convolution accelerator byte-serial port.
// Serialises weights/pixels, waits out the pipeline, then rebuilds the 18-bit sum from two tagged halves.
module conv2x2_host_driver #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RESP_DELAY    = 1,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_job_valid,
  output logic        o_job_ready,
  input  logic [31:0] i_job_pix,
  input  logic [31:0] i_job_wt,
  input  logic        i_job_load_w,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [17:0] o_res_data,
  output logic        o_err_timeout,
  output logic [7:0]  o_acc_data,
  output logic        o_acc_rd,
  output logic        o_acc_wt,
  output logic        o_acc_l1,
  input  logic [9:0]  i_rsp_in
);

  localparam int unsigned SETTLE_LEN = SETTLE_CYCLES + RESP_DELAY;
  localparam int unsigned CNT_MAX0   = (TIMEOUT > SETTLE_LEN) ? TIMEOUT : SETTLE_LEN;
  localparam int unsigned CNT_MAX    = (CNT_MAX0 > 4) ? CNT_MAX0 : 4;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_L1, S_LOAD_L2, S_SETTLE, S_CAPTURE, S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pix;
  logic [31:0]      r_wt;
  logic             r_got_lo;
  logic             r_got_hi;
  logic             r_job_ready;
  logic             r_res_valid;
  logic [17:0]      r_res_data;
  logic             r_err;
  logic [7:0]       r_acc_data;
  logic             r_acc_rd;
  logic             r_acc_wt;
  logic             r_acc_l1;

  logic             w_flag;
  logic [8:0]       w_half;
  logic             w_got_lo;
  logic             w_got_hi;

  assign w_flag   = i_rsp_in[9];
  assign w_half   = i_rsp_in[8:0];
  assign w_got_lo = r_got_lo | ~w_flag;
  assign w_got_hi = r_got_hi | w_flag;

  function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = v[7:0];
      2'd1:    byte_sel = v[15:8];
      2'd2:    byte_sel = v[23:16];
      default: byte_sel = v[31:24];
    endcase
  endfunction

  // Outputs are computed for the cycle after each edge; unless a state drives a byte, the HOLD pattern goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pix       <= '0;
      r_wt        <= '0;
      r_got_lo    <= 1'b0;
      r_got_hi    <= 1'b0;
      r_job_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
      r_acc_data  <= 8'h00;
      r_acc_rd    <= 1'b1;
      r_acc_wt    <= 1'b0;
      r_acc_l1    <= 1'b0;
    end else begin
      r_acc_data <= 8'h00;
      r_acc_rd   <= 1'b1;
      r_acc_wt   <= 1'b0;
      r_acc_l1   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_job_ready && i_job_valid) begin
            r_pix       <= i_job_pix;
            r_wt        <= i_job_wt;
            r_job_ready <= 1'b0;
            r_err       <= 1'b0;
            r_res_data  <= '0;
            r_cnt       <= '0;
            r_acc_rd    <= 1'b0;
            if (i_job_load_w) begin
              r_state    <= S_LOAD_W;
              r_acc_wt   <= 1'b1;
              r_acc_data <= i_job_wt[7:0];
            end else begin
              r_state    <= S_LOAD_L1;
              r_acc_l1   <= 1'b1;
              r_acc_data <= i_job_pix[7:0];
            end
          end else begin
            r_job_ready <= 1'b1;
          end
        end
        S_LOAD_W: begin
          r_acc_rd <= 1'b0;
          if (r_cnt == CNT_W'(3)) begin
            r_state    <= S_LOAD_L1;
            r_cnt      <= '0;
            r_acc_l1   <= 1'b1;
            r_acc_data <= r_pix[7:0];
          end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_acc_wt   <= 1'b1;
            r_acc_data <= byte_sel(r_wt, r_cnt[1:0] + 2'd1);
          end
        end
        S_LOAD_L1: begin
          r_acc_rd <= 1'b0;
          if (r_cnt == CNT_W'(1)) begin
            r_state    <= S_LOAD_L2;
            r_cnt      <= '0;
            r_acc_data <= r_pix[23:16];
          end else begin
            r_cnt      <= CNT_W'(1);
            r_acc_l1   <= 1'b1;
            r_acc_data <= r_pix[15:8];
          end
        end
        S_LOAD_L2: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
          end else begin
            r_cnt      <= CNT_W'(1);
            r_acc_rd   <= 1'b0;
            r_acc_data <= r_pix[31:24];
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_W'(SETTLE_LEN - 1)) begin
            r_state  <= S_CAPTURE;
            r_cnt    <= '0;
            r_got_lo <= 1'b0;
            r_got_hi <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (w_flag) r_res_data[17:9] <= w_half;
          else        r_res_data[8:0]  <= w_half;
          r_got_lo <= w_got_lo;
          r_got_hi <= w_got_hi;
          if (w_got_lo && w_got_hi) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_err       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_job_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_job_ready   = r_job_ready;
  assign o_res_valid   = r_res_valid;
  assign o_res_data    = r_res_data;
  assign o_err_timeout = r_err;
  assign o_acc_data    = r_acc_data;
  assign o_acc_rd      = r_acc_rd;
  assign o_acc_wt      = r_acc_wt;
  assign o_acc_l1      = r_acc_l1;

endmodule

// File: tb/tb_conv2x2_host_driver.sv
// Bench for conv2x2_host_driver: accelerator model on the byte port, table vectors, random jobs,
// timeout, backpressure and mid-load reset sequences.
module tb_conv2x2_host_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_pix;
  logic [31:0] job_wt;
  logic        job_load_w;
  logic        res_valid;
  logic        res_ready;
  logic [17:0] res_data;
  logic        err_timeout;
  logic [7:0]  acc_data;
  logic        acc_rd;
  logic        acc_wt;
  logic        acc_l1;
  logic [9:0]  rsp_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv2x2_host_driver dut (
    .clk(clk), .rst_n(rst_n),
    .i_job_valid(job_valid), .o_job_ready(job_ready), .i_job_pix(job_pix),
    .i_job_wt(job_wt), .i_job_load_w(job_load_w),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
    .o_err_timeout(err_timeout),
    .o_acc_data(acc_data), .o_acc_rd(acc_rd), .o_acc_wt(acc_wt), .o_acc_l1(acc_l1),
    .i_rsp_in(rsp_in)
  );

  // Accelerator model: shift registers written when rd=0, response halves alternate every cycle
  logic [7:0]  m_w [4];
  logic [7:0]  m_l1[2];
  logic [7:0]  m_l2[2];
  logic        m_ph = 1'b0;
  logic        m_only_lo = 1'b0;
  logic [17:0] m_sum;
  logic [9:0]  stream[$];

  initial begin
    for (int i = 0; i < 4; i++) m_w[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin m_l1[i] = 8'h00; m_l2[i] = 8'h00; end
    rsp_in = 10'h000;
  end

  always @(posedge clk) begin
    m_sum = 18'(m_l1[0]) * 18'(m_w[0]) + 18'(m_l1[1]) * 18'(m_w[1])
          + 18'(m_l2[0]) * 18'(m_w[2]) + 18'(m_l2[1]) * 18'(m_w[3]);
    if (!acc_rd) begin
      stream.push_back({acc_wt, acc_l1, acc_data});
      if (acc_wt) begin
        m_w[0] <= m_w[1]; m_w[1] <= m_w[2]; m_w[2] <= m_w[3]; m_w[3] <= acc_data;
      end else if (acc_l1) begin
        m_l1[0] <= m_l1[1]; m_l1[1] <= acc_data;
      end else begin
        m_l2[0] <= m_l2[1]; m_l2[1] <= acc_data;
      end
    end
    rsp_in <= (m_ph && !m_only_lo) ? {1'b1, m_sum[17:9]} : {1'b0, m_sum[8:0]};
    m_ph   <= ~m_ph;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ref_sum(input logic [31:0] pix, input logic [31:0] wt);
    logic [17:0] s = '0;
    for (int i = 0; i < 4; i++) s += 18'(pix[8*i +: 8]) * 18'(wt[8*i +: 8]);
    return s;
  endfunction

  task automatic check_hold(input string tag);
    check({tag, ".rd"}, 32'(acc_rd), 1);
    check({tag, ".wt"}, 32'(acc_wt), 0);
    check({tag, ".l1"}, 32'(acc_l1), 0);
    check({tag, ".data"}, 32'(acc_data), 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!job_ready && n < 50) begin @(negedge clk); n++; end
    check("job_ready_wait", 32'(job_ready), 1);
  endtask

  // One job end to end: accept, stream, latency, result, backpressure, release
  task automatic run_job(input logic [31:0] pix, input logic [31:0] wt, input logic lw,
                         input int hold, input logic to, input logic [17:0] exp_data,
                         input int exp_lat);
    int lat;
    logic [9:0] exp_q[$];
    wait_ready();
    stream.delete();
    job_pix = pix; job_wt = wt; job_load_w = lw; job_valid = 1'b1;
    @(posedge clk);
    #1;
    job_valid = 1'b0; job_pix = $urandom; job_wt = $urandom; job_load_w = 1'($urandom);
    @(negedge clk);
    check("err_cleared_on_accept", 32'(err_timeout), 0);
    check("job_ready_busy", 32'(job_ready), 0);
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("res_data", 32'(res_data), 32'(exp_data));
    check("err_timeout", 32'(err_timeout), 32'(to));
    if (lw) for (int i = 0; i < 4; i++) exp_q.push_back({2'b10, wt[8*i +: 8]});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, (i < 2), pix[8*i +: 8]});
    check("stream_len", 32'(stream.size()), 32'(exp_q.size()));
    if (stream.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("stream[%0d]", i), 32'(stream[i]), 32'(exp_q[i]));
    check_hold("done_hold");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_res_valid", 32'(res_valid), 1);
      check("bp_res_data", 32'(res_data), 32'(exp_data));
      check("bp_job_ready", 32'(job_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("res_valid_drop", 32'(res_valid), 0);
    check("job_ready_back", 32'(job_ready), 1);
  endtask

  typedef struct {
    logic [31:0] pix;
    logic [31:0] wt;
    logic        lw;
    int          hold;
    logic [17:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] cur_w;

  initial begin
    vecs[0] = '{32'h04030201, 32'h08070605, 1'b1, 10, 18'h00046, 13};
    vecs[1] = '{32'h01010101, 32'hDEADBEEF, 1'b0, 0,  18'h0001A, 9};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2,  18'h3F804, 13};
    vecs[3] = '{32'h00FF0080, 32'h12345678, 1'b0, 1,  18'h17D81, 9};
    vecs[4] = '{32'h00000000, 32'h11223344, 1'b1, 0,  18'h00000, 13};

    rst_n = 1'b0; job_valid = 1'b0; job_pix = '0; job_wt = '0; job_load_w = 1'b0; res_ready = 1'b0;
    #12;
    check("rst_job_ready", 32'(job_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_err", 32'(err_timeout), 0);
    check_hold("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++)
      run_job(vecs[v].pix, vecs[v].wt, vecs[v].lw, vecs[v].hold, 1'b0,
              vecs[v].exp_data, vecs[v].exp_lat);
    cur_w = vecs[4].wt;

    for (int k = 0; k < 20; k++) begin
      logic [31:0] p, w;
      logic lw;
      p = $urandom; w = $urandom; lw = 1'($urandom);
      if (lw) cur_w = w;
      run_job(p, w, lw, $urandom_range(0, 3), 1'b0, ref_sum(p, cur_w), lw ? 13 : 9);
    end

    // Only low halves come back: capture window expires, partial data delivered
    begin
      logic [31:0] p, w;
      logic [17:0] s;
      p = $urandom; w = $urandom; cur_w = w; s = ref_sum(p, w);
      m_only_lo = 1'b1;
      run_job(p, w, 1'b1, 1, 1'b1, {9'h000, s[8:0]}, 75);
      m_only_lo = 1'b0;
      p = $urandom;
      run_job(p, 32'h0, 1'b0, 0, 1'b0, ref_sum(p, cur_w), 9);
    end

    // Reset in the middle of the line1 load aborts to the HOLD pattern at once
    begin
      int n = 0;
      logic [31:0] p, w;
      wait_ready();
      job_pix = $urandom; job_wt = $urandom; job_load_w = 1'b1; job_valid = 1'b1;
      @(posedge clk);
      #1 job_valid = 1'b0;
      @(negedge clk);
      while (!acc_l1 && n < 20) begin @(negedge clk); n++; end
      check("reach_load_l1", 32'(acc_l1), 1);
      #2 rst_n = 1'b0;
      #1;
      check_hold("mid_rst");
      check("mid_rst_job_ready", 32'(job_ready), 0);
      check("mid_rst_res_valid", 32'(res_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      p = $urandom; w = $urandom; cur_w = w;
      run_job(p, w, 1'b1, 0, 1'b0, ref_sum(p, w), 13);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
